// File: rtl/conv_pkg.sv
// Shared definitions for the spike-gated convolution tree accumulator:
// pipeline geometry helpers, the per-stage control tag and saturation limits.
package conv_pkg;

    // Number of registered adder-tree levels for a power-of-two lane count.
    function automatic int log2w(input int weights);
        return $clog2(weights);
    endfunction

    // Cycles from a sample's en to its valid: lane register, tree levels, accumulator.
    function automatic int latency(input int weights);
        return $clog2(weights) + 2;
    endfunction

    // Geometry of the default four-lane configuration.
    localparam int DEF_WEIGHTS = 4;
    localparam int DEF_LOG2W   = $clog2(DEF_WEIGHTS);
    localparam int DEF_L       = DEF_LOG2W + 2;

    // Control carried beside each sample through the pipeline.
    typedef struct packed {
        logic en;
        logic clear_and_go;
    } tag_t;

    // Largest positive two's-complement value of the given width, in 64 bits.
    function automatic logic [63:0] sat_pos(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width, in 64 bits.
    function automatic logic [63:0] sat_neg(input int width);
        return ~sat_pos(width);
    endfunction

endpackage

// File: rtl/conv_adder_level.sv
// One registered level of the adder tree: adds adjacent signed pairs,
// growing the width by one bit so no overflow can occur. Holds when load=0.
module conv_adder_level #(
    parameter int IN_COUNT = 4,
    parameter int IN_WIDTH = 15
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     load,
    input  logic [IN_COUNT*IN_WIDTH-1:0]             in_data,
    output logic [(IN_COUNT/2)*(IN_WIDTH+1)-1:0]     out_data
);

    localparam int OUT_COUNT = IN_COUNT / 2;
    localparam int OUT_WIDTH = IN_WIDTH + 1;

    logic [OUT_COUNT*OUT_WIDTH-1:0] pair_sum;

    // Sign-extend each lane of a pair and add them.
    always_comb begin
        // NOTE: default assignment first so every path drives pair_sum; no latch.
        pair_sum = '0;
        for (int k = 0; k < OUT_COUNT; k++) begin
            pair_sum[k*OUT_WIDTH +: OUT_WIDTH] =
                OUT_WIDTH'($signed(in_data[(2*k)*IN_WIDTH +: IN_WIDTH])) +
                OUT_WIDTH'($signed(in_data[(2*k+1)*IN_WIDTH +: IN_WIDTH]));
        end
    end

    // Capture the pair sums when this level's sample tag is set.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state.
        if (rst) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= pair_sum;
        end
    end

endmodule

// File: rtl/conv_tree_acc.sv
// Spike-gated convolution unit: gates WEIGHTS signed weights by spikes,
// reduces them through a fully registered binary adder tree and accumulates
// the result. Control tags (en, clear_and_go) travel beside the data.
// Optional build macro CONV_TREE_ACC_SAT_EN: saturating accumulation with a
// sticky overflow flag (sat_flag); otherwise the accumulator wraps.
module conv_tree_acc
    import conv_pkg::*;
#(
    parameter int WEIGHTS    = 4,
    parameter int DATA_WIDTH = 15,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          acc_clear_and_go,
    input  logic                          acc_clear,
    input  logic [WEIGHTS*DATA_WIDTH-1:0] weights_in,
    input  logic [WEIGHTS-1:0]            spikes,
    output logic [ACC_WIDTH-1:0]          out,
    output logic                          valid
);

    localparam int LOG2W = log2w(WEIGHTS);
    localparam int L     = latency(WEIGHTS);
    localparam int SUM_W = DATA_WIDTH + LOG2W;

    // Tag for the sample held in stage k; tag_q[LOG2W] is the sample arriving
    // at the accumulator, tag_q[L-1] the one whose result is in acc_q.
    tag_t tag_q [L];

    logic [WEIGHTS*DATA_WIDTH-1:0] lane_gated;
    logic [WEIGHTS*DATA_WIDTH-1:0] lane_q;
    logic signed [SUM_W-1:0]       tree_sum;
    logic signed [ACC_WIDTH-1:0]   sum_ext;
    logic signed [ACC_WIDTH-1:0]   add_result;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    tag_t                          arrive;

    // Zero the weight of every lane whose spike is low.
    always_comb begin
        lane_gated = '0;
        for (int k = 0; k < WEIGHTS; k++) begin
            if (spikes[k]) begin
                lane_gated[k*DATA_WIDTH +: DATA_WIDTH] = weights_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stage 0 lane register, loaded only for valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else if (en) begin
            lane_q <= lane_gated;
        end
    end

    // Tag shift register; clear_and_go only means something with en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{en: en, clear_and_go: en & acc_clear_and_go};
            for (int k = 1; k < L; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    for (genvar j = 0; j < LOG2W; j++) begin : g_level
        localparam int IN_N = WEIGHTS >> j;
        localparam int IN_W = DATA_WIDTH + j;

        logic [IN_N*IN_W-1:0]           level_in;
        logic [(IN_N/2)*(IN_W+1)-1:0]   level_out;

        if (j == 0) begin : g_first
            assign level_in = lane_q;
        end else begin : g_next
            assign level_in = g_level[j-1].level_out;
        end

        conv_adder_level #(
            .IN_COUNT (IN_N),
            .IN_WIDTH (IN_W)
        ) u_level (
            .clk      (clk),
            .rst      (rst),
            .load     (tag_q[j].en),
            .in_data  (level_in),
            .out_data (level_out)
        );
    end

    assign tree_sum = g_level[LOG2W-1].level_out;
    assign sum_ext  = ACC_WIDTH'(tree_sum);
    assign arrive   = tag_q[LOG2W];

`ifdef CONV_TREE_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_pos(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_neg(ACC_WIDTH));

    logic [ACC_WIDTH:0] wide_sum;
    logic               overflow;
    logic               sat_flag;

    // One-bit-wider add; disagreeing top bits mean the result left the range.
    always_comb begin
        wide_sum = {acc_q[ACC_WIDTH-1], acc_q} + {sum_ext[ACC_WIDTH-1], sum_ext};
        overflow = wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1];
        if (!overflow) begin
            add_result = wide_sum[ACC_WIDTH-1:0];
        end else if (wide_sum[ACC_WIDTH]) begin
            add_result = ACC_MIN;
        end else begin
            add_result = ACC_MAX;
        end
    end

    // Sticky record that the accumulator clamped since its last clear.
    always_ff @(posedge clk) begin
        if (rst || acc_clear || (arrive.en && arrive.clear_and_go)) begin
            sat_flag <= 1'b0;
        end else if (arrive.en && overflow) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign add_result = acc_q + sum_ext;
`endif

    // Accumulator: explicit clear wins, then replace, then add, else hold.
    always_ff @(posedge clk) begin
        if (rst || acc_clear) begin
            acc_q <= '0;
        end else if (arrive.en) begin
            acc_q <= arrive.clear_and_go ? sum_ext : add_result;
        end
    end

    assign valid = tag_q[L-1].en;
    assign out   = valid ? acc_q : '0;

endmodule

// File: tb/tb_conv_tree_acc.sv
// Directed bench for conv_tree_acc: three instances cover the default
// four-lane unit, a narrow accumulator that overflows, and the two-lane
// degenerate tree. Expected values are hand-computed.
module tb_conv_tree_acc;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: WEIGHTS=4, DATA_WIDTH=15, ACC_WIDTH=32
    logic        en_a, cg_a, clr_a;
    logic [59:0] w_a;
    logic [3:0]  sp_a;
    logic [31:0] out_a;
    logic        valid_a;

    // Instance B: WEIGHTS=4, DATA_WIDTH=8, ACC_WIDTH=12
    logic        en_b, cg_b, clr_b;
    logic [31:0] w_b;
    logic [3:0]  sp_b;
    logic [11:0] out_b;
    logic        valid_b;

    // Instance C: WEIGHTS=2, DATA_WIDTH=15, ACC_WIDTH=32
    logic        en_c, cg_c, clr_c;
    logic [29:0] w_c;
    logic [1:0]  sp_c;
    logic [31:0] out_c;
    logic        valid_c;

    int checks = 0;
    int errors = 0;

    conv_tree_acc #(.WEIGHTS(4), .DATA_WIDTH(15), .ACC_WIDTH(32)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .acc_clear_and_go(cg_a), .acc_clear(clr_a),
        .weights_in(w_a), .spikes(sp_a), .out(out_a), .valid(valid_a)
    );

    conv_tree_acc #(.WEIGHTS(4), .DATA_WIDTH(8), .ACC_WIDTH(12)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .acc_clear_and_go(cg_b), .acc_clear(clr_b),
        .weights_in(w_b), .spikes(sp_b), .out(out_b), .valid(valid_b)
    );

    conv_tree_acc #(.WEIGHTS(2), .DATA_WIDTH(15), .ACC_WIDTH(32)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .acc_clear_and_go(cg_c), .acc_clear(clr_c),
        .weights_in(w_c), .spikes(sp_c), .out(out_c), .valid(valid_c)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic exp_valid, input longint exp_out);
        check({tag, "_valid"}, longint'(valid_a), longint'(exp_valid));
        check({tag, "_out"}, longint'($signed(out_a)), exp_out);
    endtask

    longint exp_b [5];

    initial begin
        rst  = 1'b1;
        en_a = 1'b0; cg_a = 1'b0; clr_a = 1'b0; sp_a = 4'b1011;
        en_b = 1'b0; cg_b = 1'b0; clr_b = 1'b0; sp_b = 4'b1111;
        en_c = 1'b0; cg_c = 1'b0; clr_c = 1'b0; sp_c = 2'b11;

        // Lanes 3..0 = {2, 7, -3, 10}; spikes 1011 select 10 - 3 + 2 = 9
        w_a[0*15 +: 15] = 15'd10;
        w_a[1*15 +: 15] = -15'sd3;
        w_a[2*15 +: 15] = 15'd7;
        w_a[3*15 +: 15] = 15'd2;
        for (int k = 0; k < 4; k++) w_b[k*8 +: 8] = 8'd127;
        // Lanes 1..0 = {-7, 5}
        w_c[0*15 +: 15] = 15'd5;
        w_c[1*15 +: 15] = -15'sd7;

        // Reset state; en during rst must be ignored
        en_a = 1'b1;
        tick();
        tick();
        en_a = 1'b0;
        check_a("rst_a", 1'b0, 0);
        check("rst_b_valid", longint'(valid_b), 0);
        check("rst_c_valid", longint'(valid_c), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a("rst_en_ignored", 1'b0, 0);
        end

        // Two-lane tree: latency 3, sum 5 + (-7) = -2
        en_c = 1'b1; cg_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            en_c = 1'b0; cg_c = 1'b0;
            check("w2_valid", longint'(valid_c), (i == 2) ? 1 : 0);
            check("w2_out", longint'($signed(out_c)), (i == 2) ? -2 : 0);
        end

        // Single clear_and_go sample: valid after 4 cycles, out = 9
        en_a = 1'b1; cg_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            en_a = 1'b0; cg_a = 1'b0;
            check_a("single", (i == 3), (i == 3) ? 9 : 0);
        end

        // Standalone clear, then three back-to-back samples: 9, 18, 27
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check_a("clear_idle", 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            en_a = (i < 3);
            tick();
            check_a("b2b", (i >= 3 && i <= 5), (i >= 3 && i <= 5) ? 9 * (i - 2) : 0);
        end

        // acc_clear collides with an arriving sample: out 0, next sample 9
        for (int i = 0; i < 6; i++) begin
            en_a  = (i < 2);
            clr_a = (i == 3);
            tick();
            if (i == 3)      check_a("clr_collide", 1'b1, 0);
            else if (i == 4) check_a("after_collide", 1'b1, 9);
            else             check_a("collide_idle", 1'b0, 0);
        end
        clr_a = 1'b0;

        // No spikes: sum 0 added, valid still pulses with the held acc
        sp_a = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            en_a = (i == 0);
            tick();
            check_a("zero_spk", (i == 3), (i == 3) ? 9 : 0);
        end
        sp_a = 4'b1011;

        // Narrow accumulator: 4 * 127 per sample, fifth add overflows 12 bits
        exp_b[0] = 508; exp_b[1] = 1016; exp_b[2] = 1524; exp_b[3] = 2032;
`ifdef CONV_TREE_ACC_SAT_EN
        exp_b[4] = 2047;
`else
        exp_b[4] = -1556;
`endif
        for (int i = 0; i < 9; i++) begin
            en_b = (i < 5);
            cg_b = (i == 0);
            tick();
            check("ovf_valid", longint'(valid_b), (i >= 3 && i <= 7) ? 1 : 0);
            check("ovf_out", longint'($signed(out_b)), (i >= 3 && i <= 7) ? exp_b[i-3] : 0);
        end
`ifdef CONV_TREE_ACC_SAT_EN
        check("sat_flag", longint'(u_b.sat_flag), 1);
`endif

        // Reset with three samples in flight: all lost, fresh sample alone
        for (int i = 0; i < 3; i++) begin
            en_a = 1'b1;
            cg_a = (i == 0);
            tick();
            check_a("inflight", 1'b0, 0);
        end
        cg_a = 1'b0;
        rst  = 1'b1;
        tick();
        check_a("mid_rst", 1'b0, 0);
        rst  = 1'b0;
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a("post_rst", 1'b0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            en_a = (i == 0);
            tick();
            check_a("fresh", (i == 3), (i == 3) ? 9 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
